// File: rtl/cond_exec_seq_pkg.sv
// ---------------------------------------------------------------------------
// cond_exec_seq_pkg
// Shared definitions for the conditional-execution sequencer:
//   - condition code encodings (EQ..AL plus the never-execute code NV)
//   - bit positions of the NZCV flags inside the packed {z,c,n,v} status word
//   - the IT-block state record (3-bit base condition + 5-bit shift window)
//   - a helper that decides whether an IT instruction may start a block
// ---------------------------------------------------------------------------
package cond_exec_seq_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0,
        NE = 4'h1,
        CS = 4'h2,
        CC = 4'h3,
        MI = 4'h4,
        PL = 4'h5,
        VS = 4'h6,
        VC = 4'h7,
        HI = 4'h8,
        LS = 4'h9,
        GE = 4'hA,
        LT = 4'hB,
        GT = 4'hC,
        LE = 4'hD,
        AL = 4'hE,
        NV = 4'hF
    } cond_e;

    // Status word is packed {z,c,n,v}
    localparam int Z = 3;
    localparam int C = 2;
    localparam int N = 1;
    localparam int V = 0;

    // shift[4] is the low condition bit for the next instruction in the block;
    // shift[3:0] holds the remaining mask, non-zero while the block is live.
    typedef struct packed {
        logic [2:0] base;
        logic [4:0] shift;
    } it_state_t;

    // An IT may open a block only when its mask is non-empty, its firstcond is
    // not NV, no block is already running, and an AL block is exactly one long.
    function automatic logic it_legal(input logic [3:0] firstcond,
                                      input logic [3:0] mask,
                                      input logic       active);
        logic ok;
        ok = (mask != 4'b0000) && (firstcond != 4'b1111) && !active;
        if ((firstcond == 4'b1110) && (mask != 4'b1000))
            ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/cond_exec_seq_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code evaluator.
// Ports:
//   cond   - 4-bit condition code
//   status - flags packed {z,c,n,v}
//   pass   - 1 when the condition holds on the given flags
// ---------------------------------------------------------------------------
module cond_eval
    import cond_exec_seq_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] status,
    output logic       pass
);

    logic z;
    logic c;
    logic n;
    logic v;

    assign z = status[Z];
    assign c = status[C];
    assign n = status[N];
    assign v = status[V];

    // NV deliberately never passes; it marks a rejected IT travelling as a NOP.
    always_comb begin
        pass = 1'b0;
        case (cond_e'(cond))
            EQ:      pass = z;
            NE:      pass = ~z;
            CS:      pass = c;
            CC:      pass = ~c;
            MI:      pass = n;
            PL:      pass = ~n;
            VS:      pass = v;
            VC:      pass = ~v;
            HI:      pass = c & ~z;
            LS:      pass = ~c | z;
            GE:      pass = (n == v);
            LT:      pass = (n != v);
            GT:      pass = ~z & (n == v);
            LE:      pass = z | (n != v);
            AL:      pass = 1'b1;
            NV:      pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_seq.sv
// ---------------------------------------------------------------------------
// cond_exec_seq
// Conditional-execution sequencer sitting between decode and execute. It owns
// the NZCV status register and the IT-block state, chooses the effective
// condition for every accepted instruction, registers it into the EX slot and
// evaluates it there against the status register.
// Ports:
//   clk, rst           - clock (rising edge), asynchronous active-high reset
//   in_valid           - decode instruction present
//   in_cond            - instruction's own condition field
//   in_set_flags       - instruction writes flags (S bit)
//   in_is_it           - instruction is an IT
//   in_it_firstcond    - IT firstcond field
//   in_it_mask         - IT mask field
//   stall              - freeze all state
//   flush              - pipeline redirect, drops decode and the IT block
//   alu_flags          - flags produced by the EX instruction, {z,c,n,v}
//   ex_valid, ex_cond  - EX slot occupancy and its effective condition
//   ex_exec            - EX instruction passes its condition
//   ex_wr_flags        - EX instruction executes and writes flags
//   status             - status register {z,c,n,v}
//   it_active          - an IT block is in progress
//   it_error           - one-cycle pulse after an illegal IT was accepted
// ---------------------------------------------------------------------------
module cond_exec_seq
    import cond_exec_seq_pkg::*;
#(
    parameter logic [3:0] AL_COND = 4'b1110
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] in_cond,
    input  logic       in_set_flags,
    input  logic       in_is_it,
    input  logic [3:0] in_it_firstcond,
    input  logic [3:0] in_it_mask,
    input  logic       stall,
    input  logic       flush,
    input  logic [3:0] alu_flags,
    output logic       ex_valid,
    output logic [3:0] ex_cond,
    output logic       ex_exec,
    output logic       ex_wr_flags,
    output logic [3:0] status,
    output logic       it_active,
    output logic       it_error
);

    logic       ex_valid_q, ex_valid_d;
    logic [3:0] ex_cond_q, ex_cond_d;
    logic       ex_sf_q, ex_sf_d;
    logic [3:0] status_q, status_d;
    it_state_t  it_q, it_d;
    logic       it_error_q, it_error_d;

    logic       cond_pass;
    logic [3:0] eff_cond;
    logic       it_ok;

    cond_eval u_cond_eval (
        .cond   (ex_cond_q),
        .status (status_q),
        .pass   (cond_pass)
    );

    // State register: everything clears on reset, which also abandons any
    // IT block in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_cond_q  <= 4'b0000;
            ex_sf_q    <= 1'b0;
            status_q   <= 4'b0000;
            it_q       <= '0;
            it_error_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_cond_q  <= ex_cond_d;
            ex_sf_q    <= ex_sf_d;
            status_q   <= status_d;
            it_q       <= it_d;
            it_error_q <= it_error_d;
        end
    end

    // Next-state logic. The flag commit belongs to the instruction already in
    // EX, so it is decided independently of flush; only stall suppresses it.
    // Flush outranks stall so a redirect always empties the slot and the block.
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_cond_d  = ex_cond_q;
        ex_sf_d    = ex_sf_q;
        status_d   = status_q;
        it_d       = it_q;
        it_error_d = 1'b0;

        eff_cond = it_active ? {it_q.base, it_q.shift[4]} : in_cond;
        it_ok    = it_legal(in_it_firstcond, in_it_mask, it_active);

        if (ex_wr_flags && !stall)
            status_d = alu_flags;

        if (flush) begin
            ex_valid_d = 1'b0;
            it_d       = '0;
        end else if (!stall) begin
            if (in_valid) begin
                ex_valid_d = 1'b1;
                if (in_is_it) begin
                    ex_sf_d = 1'b0;
                    if (it_ok) begin
                        ex_cond_d = AL_COND;
                        it_d.base  = in_it_firstcond[3:1];
                        it_d.shift = {in_it_firstcond[0], in_it_mask};
                    end else begin
                        // Rejected IT rides through EX as a never-executing NOP.
                        ex_cond_d  = NV;
                        it_error_d = 1'b1;
                    end
                end else begin
                    ex_cond_d = eff_cond;
                    ex_sf_d   = in_set_flags;
                    // The terminating 1 in the mask reaching bit 3 means this
                    // was the last slot of the block.
                    if (it_active) begin
                        if (it_q.shift[3:0] == 4'b1000)
                            it_d.shift = 5'b00000;
                        else
                            it_d.shift = {it_q.shift[3:0], 1'b0};
                    end
                end
            end else begin
                ex_valid_d = 1'b0;
            end
        end
    end

    // Outputs are derived from registered state only.
    always_comb begin
        ex_valid    = ex_valid_q;
        ex_cond     = ex_cond_q;
        ex_exec     = ex_valid_q & cond_pass;
        ex_wr_flags = ex_valid_q & cond_pass & ex_sf_q;
        status      = status_q;
        it_active   = (it_q.shift[3:0] != 4'b0000);
        it_error    = it_error_q;
    end

endmodule

// File: tb/tb_cond_exec_seq.sv
// ---------------------------------------------------------------------------
// tb_cond_exec_seq
// Self-checking bench for cond_exec_seq. Each accepted instruction pushes its
// expected EX result onto a scoreboard queue; the entry is popped and compared
// when the instruction shows up in the EX slot.
// ---------------------------------------------------------------------------
module tb_cond_exec_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_cond;
    logic       in_set_flags;
    logic       in_is_it;
    logic [3:0] in_it_firstcond;
    logic [3:0] in_it_mask;
    logic       stall;
    logic       flush;
    logic [3:0] alu_flags;
    logic       ex_valid;
    logic [3:0] ex_cond;
    logic       ex_exec;
    logic       ex_wr_flags;
    logic [3:0] status;
    logic       it_active;
    logic       it_error;

    typedef struct packed {
        logic [3:0] cond;
        logic       exec;
        logic       wr;
    } sb_t;

    sb_t  sb_queue[$];
    int   check_count = 0;
    int   pass_count  = 0;
    logic last_valid  = 1'b0;
    logic [3:0] status_list [3] = '{4'b0110, 4'b1001, 4'b0011};

    cond_exec_seq dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_cond         (in_cond),
        .in_set_flags    (in_set_flags),
        .in_is_it        (in_is_it),
        .in_it_firstcond (in_it_firstcond),
        .in_it_mask      (in_it_mask),
        .stall           (stall),
        .flush           (flush),
        .alu_flags       (alu_flags),
        .ex_valid        (ex_valid),
        .ex_cond         (ex_cond),
        .ex_exec         (ex_exec),
        .ex_wr_flags     (ex_wr_flags),
        .status          (status),
        .it_active       (it_active),
        .it_error        (it_error)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check_count++;
        if (obs === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Condition table written straight from the architectural definition.
    function automatic logic expPass(input logic [3:0] c, input logic [3:0] s);
        logic z, cy, n, v, r;
        z  = s[3];
        cy = s[2];
        n  = s[1];
        v  = s[0];
        case (c)
            4'h0: r = (z == 1'b1);
            4'h1: r = (z == 1'b0);
            4'h2: r = (cy == 1'b1);
            4'h3: r = (cy == 1'b0);
            4'h4: r = (n == 1'b1);
            4'h5: r = (n == 1'b0);
            4'h6: r = (v == 1'b1);
            4'h7: r = (v == 1'b0);
            4'h8: r = (cy == 1'b1) && (z == 1'b0);
            4'h9: r = (cy == 1'b0) || (z == 1'b1);
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = (z == 1'b0) && (n == v);
            4'hD: r = (z == 1'b1) || (n != v);
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs, push the expected EX entry if accepted, then
    // check the slot one edge later.
    task automatic applyStimulus(input logic v, input logic [3:0] c, input logic sf,
                                 input logic it, input logic [3:0] fc, input logic [3:0] mk,
                                 input logic st, input logic fl, input logic [3:0] af,
                                 input logic [3:0] e_cond, input logic e_exec, input logic e_wr);
        logic acc;
        logic exp_valid;
        sb_t  e;
        in_valid        = v;
        in_cond         = c;
        in_set_flags    = sf;
        in_is_it        = it;
        in_it_firstcond = fc;
        in_it_mask      = mk;
        stall           = st;
        flush           = fl;
        alu_flags       = af;
        acc = v & ~st & ~fl;
        if (acc) begin
            e.cond = e_cond;
            e.exec = e_exec;
            e.wr   = e_wr;
            sb_queue.push_back(e);
        end
        @(posedge clk);
        #1;
        exp_valid  = fl ? 1'b0 : (st ? last_valid : acc);
        last_valid = exp_valid;
        checkOutput("ex_valid", 8'(ex_valid), 8'(exp_valid));
        if (ex_valid && !st) begin
            checkOutput("sb_nonempty", 8'(sb_queue.size() != 0), 8'(1));
            if (sb_queue.size() != 0) begin
                e = sb_queue.pop_front();
                checkOutput("ex_cond", 8'(ex_cond), 8'(e.cond));
                checkOutput("ex_exec", 8'(ex_exec), 8'(e.exec));
                checkOutput("ex_wr_flags", 8'(ex_wr_flags), 8'(e.wr));
            end
        end
    endtask

    task automatic issue(input logic [3:0] c, input logic sf, input logic [3:0] af,
                         input logic [3:0] e_cond, input logic e_exec, input logic e_wr);
        applyStimulus(1'b1, c, sf, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, af, e_cond, e_exec, e_wr);
    endtask

    task automatic issueIt(input logic [3:0] fc, input logic [3:0] mk, input logic [3:0] af,
                           input logic [3:0] e_cond);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, fc, mk, 1'b0, 1'b0, af, e_cond, (e_cond == 4'hE), 1'b0);
    endtask

    task automatic idle(input logic [3:0] af);
        applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, af, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_cond = 4'h0; in_set_flags = 1'b0; in_is_it = 1'b0;
        in_it_firstcond = 4'h0; in_it_mask = 4'h0; stall = 1'b0; flush = 1'b0;
        alu_flags = 4'h0;
        #12;
        checkOutput("rst_status", 8'(status), 8'(0));
        checkOutput("rst_ex_valid", 8'(ex_valid), 8'(0));
        checkOutput("rst_ex_cond", 8'(ex_cond), 8'(0));
        checkOutput("rst_it_active", 8'(it_active), 8'(0));
        checkOutput("rst_it_error", 8'(it_error), 8'(0));
        checkOutput("rst_ex_wr_flags", 8'(ex_wr_flags), 8'(0));
        @(negedge clk);
        rst = 1'b0;

        // ADDS sets Z, then BEQ executes and BNE does not.
        issue(4'hE, 1'b1, 4'b0000, 4'hE, 1'b1, 1'b1);
        issue(4'h0, 1'b0, 4'b1000, 4'h0, 1'b1, 1'b0);
        checkOutput("status_after_adds", 8'(status), 8'(4'b1000));
        issue(4'h1, 1'b0, 4'b0000, 4'h1, 1'b0, 1'b0);
        checkOutput("status_no_write", 8'(status), 8'(4'b1000));
        idle(4'h0);

        // Clear flags, then ITTE EQ: conds 0,0,1 then back to own cond.
        issue(4'hE, 1'b1, 4'b0000, 4'hE, 1'b1, 1'b1);
        issueIt(4'b0000, 4'b0110, 4'b0000, 4'hE);
        checkOutput("status_cleared", 8'(status), 8'(0));
        checkOutput("itte_active", 8'(it_active), 8'(1));
        issue(4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        issue(4'h5, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
        checkOutput("itte_active_2", 8'(it_active), 8'(1));
        issue(4'h5, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0);
        checkOutput("itte_done", 8'(it_active), 8'(0));
        issue(4'h4, 1'b0, 4'h0, 4'h4, 1'b0, 1'b0);

        // IT GT single slot, frozen by a 3-cycle stall.
        issueIt(4'b1100, 4'b1000, 4'h0, 4'hE);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
            checkOutput("stall_it_active", 8'(it_active), 8'(1));
            checkOutput("stall_ex_cond", 8'(ex_cond), 8'(4'hE));
        end
        issue(4'h0, 1'b1, 4'h0, 4'hC, 1'b1, 1'b1);
        checkOutput("gt_block_done", 8'(it_active), 8'(0));
        issue(4'h0, 1'b0, 4'b0100, 4'h0, 1'b0, 1'b0);
        checkOutput("status_c", 8'(status), 8'(4'b0100));

        // Illegal ITs: empty mask, AL with long mask, IT inside a block.
        issueIt(4'b0000, 4'b0000, 4'h0, 4'hF);
        checkOutput("err_empty_mask", 8'(it_error), 8'(1));
        checkOutput("err_empty_active", 8'(it_active), 8'(0));
        idle(4'h0);
        checkOutput("err_pulse_end", 8'(it_error), 8'(0));
        issueIt(4'b1110, 4'b0100, 4'h0, 4'hF);
        checkOutput("err_al_mask", 8'(it_error), 8'(1));
        issueIt(4'b0010, 4'b0010, 4'h0, 4'hE);
        checkOutput("cs_block_active", 8'(it_active), 8'(1));
        checkOutput("legal_no_err", 8'(it_error), 8'(0));
        issueIt(4'b0000, 4'b1000, 4'h0, 4'hF);
        checkOutput("err_nested", 8'(it_error), 8'(1));
        checkOutput("nested_keeps_block", 8'(it_active), 8'(1));
        issue(4'h7, 1'b1, 4'h0, 4'h2, 1'b1, 1'b1);
        checkOutput("cs_two_left", 8'(it_active), 8'(1));

        // Flush mid-block: slot and block cleared, EX flag write still lands.
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'b1111, 4'h0, 1'b0, 1'b0);
        checkOutput("flush_it_active", 8'(it_active), 8'(0));
        checkOutput("flush_status", 8'(status), 8'(4'b1111));
        issue(4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);

        // Stall with flush: slot cleared, flag write suppressed.
        issue(4'hE, 1'b1, 4'h0, 4'hE, 1'b1, 1'b1);
        applyStimulus(1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 4'b0000, 4'h0, 1'b0, 1'b0);
        checkOutput("stall_flush_status", 8'(status), 8'(4'b1111));

        // Every condition code against several flag patterns.
        foreach (status_list[k]) begin
            issue(4'hE, 1'b1, 4'h0, 4'hE, 1'b1, 1'b1);
            for (int c = 0; c < 16; c++)
                issue(4'(c), 1'b0, (c == 0) ? status_list[k] : 4'h0,
                      4'(c), expPass(4'(c), status_list[k]), 1'b0);
            checkOutput("loop_status", 8'(status), 8'(status_list[k]));
        end

        // Asynchronous reset in the middle of a block with all flags set.
        issue(4'hE, 1'b1, 4'h0, 4'hE, 1'b1, 1'b1);
        issueIt(4'b0000, 4'b1000, 4'b1111, 4'hE);
        checkOutput("pre_rst_status", 8'(status), 8'(4'b1111));
        checkOutput("pre_rst_active", 8'(it_active), 8'(1));
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_ex_valid", 8'(ex_valid), 8'(0));
        checkOutput("arst_status", 8'(status), 8'(0));
        checkOutput("arst_it_active", 8'(it_active), 8'(0));
        checkOutput("arst_ex_cond", 8'(ex_cond), 8'(0));
        checkOutput("arst_ex_exec", 8'(ex_exec), 8'(0));
        last_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        issue(4'h1, 1'b0, 4'h0, 4'h1, 1'b1, 1'b0);
        idle(4'h0);

        checkOutput("sb_empty", 8'(sb_queue.size()), 8'(0));
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cond_exec_seq.md
Name: cond_exec_seq

Overview:
- Conditional-execution sequencer between decode and execute. Owns the NZCV status register and the Thumb-style IT-block state.
- For every instruction leaving decode, it picks the effective condition: the instruction's own cond field, or the IT-derived cond inside an IT block. It registers that condition into the EX slot.
- In EX it evaluates the condition against the status register and commits flag updates from the ALU.

Parameters:
- AL_COND, 4'b1110, condition code forced onto IT instructions and out-of-block defaults.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  decode-stage instruction present; accepted when in_valid & ~stall & ~flush
- in_cond  in  4  instruction cond field (used outside IT block)
- in_set_flags  in  1  instruction has S bit
- in_is_it  in  1  instruction is IT
- in_it_firstcond  in  4  IT firstcond
- in_it_mask  in  4  IT mask
- stall  in  1  freeze all state
- flush  in  1  pipeline redirect
- alu_flags  in  4  flags produced by EX instruction, packed {z,c,n,v}
- ex_valid  out  1  EX slot occupied
- ex_cond  out  4  effective condition of EX instruction
- ex_exec  out  1  ex_valid & condition passes on current status (combinational from registered state)
- ex_wr_flags  out  1  ex_exec & EX instruction set_flags
- status  out  4  status register {z,c,n,v}
- it_active  out  1  IT block in progress
- it_error  out  1  one-cycle pulse: illegal IT rejected

Behaviour:
- Reset (async):
  - status=0000, ex_valid=0, ex_cond=0000, EX set_flags=0.
  - IT state cleared: it_active=0, it_error=0.
- Accept = in_valid & ~stall & ~flush. On accept, the EX slot loads at the next edge (latency 1).
  - Effective cond = {it_base, it_shift[4]} if it_active, else in_cond.
  - IT instruction loads ex_cond=AL_COND, set_flags=0.
- No accept and ~stall -> ex_valid<=0 (bubble).
- Condition evaluation table; status packed {z,c,n,v}:
  - 0 EQ z; 1 NE ~z; 2 CS c; 3 CC ~c; 4 MI n; 5 PL ~n; 6 VS v; 7 VC ~v
  - 8 HI c&~z; 9 LS ~c|z; A GE n==v; B LT n!=v
  - C GT ~z&(n==v); D LE z|(n!=v); E AL 1; F 0
- Flag commit: if ex_wr_flags & ~stall, status<=alu_flags at the edge. The next instruction in EX sees the new flags (no bypass needed).
- Flag commit happens even on a flush cycle; the EX instruction completes.
- IT state is it_base[2:0] plus it_shift[4:0]. it_active = (it_shift[3:0] != 0).
- Legal IT: mask != 0, firstcond != 1111, not already it_active, and not (firstcond==1110 with mask not 1000).
  - On accept of a legal IT: it_base<=firstcond[3:1], it_shift<={firstcond[0], mask}.
- Accepting a non-IT instruction while it_active consumes one slot:
  - If it_shift[3:0]==1000, it_shift<=0 (block ends).
  - Otherwise it_shift<={it_shift[3:0],0}.
- Block length: mask 1000->1, x100->2, xx10->3, xxx1->4. Instruction k>=2 takes cond[0]=mask[5-k].
- Illegal IT:
  - IT state unchanged.
  - Enters EX as a NOP: ex_valid=1, ex_cond=1111, so ex_exec=0.
  - it_error pulses the following cycle.
- Stall: nothing changes (EX slot, status, IT state hold); it_error deasserts.
- Flush (priority over stall and in_valid):
  - No accept; ex_valid<=0; IT state cleared.
  - Status commit for the current EX instruction still applies if ~stall. With stall&flush, the commit is suppressed but the slot is still cleared.
- rst mid-block: IT block abandoned immediately.

Decomposition:
- Shared package:
  - cond code constants EQ..AL and NV=4'b1111
  - status bit indices Z=3, C=2, N=1, V=0
  - it_state struct {base[2:0], shift[4:0]}
- Sub-module cond_eval: combinational cond(4), status(4) -> pass. It is instantiated once on ex_cond/status.

Test Plan:
- Reset then accept ADDS (cond E, S=1) with alu_flags=1000 -> cycle+1: ex_exec=1, ex_wr_flags=1; cycle+2: status=1000. The following BEQ (cond 0) has ex_exec=1; BNE has ex_exec=0.
- Status 0000, accept IT firstcond=0000 (EQ), mask=0110 (ITTE), then 3 instrs -> ex_cond sequence 0000,0000,0001; it_active drops after the 3rd accept. The 4th instr uses its own in_cond.
- IT GT mask 1000 then stall 3 cycles with in_valid=1 -> IT state/EX frozen. After release, the single instr gets ex_cond=1100; the next is outside the block.
- IT while it_active, or mask 0000 -> it_error=1 one cycle; NOP in EX with ex_exec=0; IT state unchanged.
- Flush asserted with in_valid=1 mid IT block (2 slots left) -> next cycle ex_valid=0, it_active=0. Status is still written if the EX instr had ex_wr_flags.
- rst asserted asynchronously mid-cycle during an IT block with status=1111 -> outputs go to reset values before the next clk edge.
